pc_unit: RTL and testbench

Parametrised program-counter unit for the MIPS datapath; it generalises the plain PC register. It selects the next PC from several sources: sequential, branch, jump, jump-register, call, return and exception. It holds the PC on stall or back-pressure and presents the PC to instruction fetch with a valid/ready handshake. A small return-address stack (RAS) supplies return targets.

---
 rtl/pc_unit.sv | 151 +++++++++++++++
 tb/tb_pc_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection with redirect priority, fetch valid/ready
// handshake and a small circular return-address stack.
module pc_unit #(
  parameter int unsigned     WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 'h80,
  parameter int unsigned     INC          = 4,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stall,
  input  logic             i_fetch_ready,
  input  logic             i_branch_taken,
  input  logic [WIDTH-1:0] i_branch_offset,
  input  logic             i_jump,
  input  logic [WIDTH-3:0] i_jump_target,
  input  logic             i_jr,
  input  logic [WIDTH-1:0] i_jr_target,
  input  logic             i_call,
  input  logic             i_ret,
  input  logic             i_exception,
  output logic [WIDTH-1:0] o_pc_out,
  output logic             o_pc_valid,
  output logic [WIDTH-1:0] o_pc_plus_inc,
  output logic             o_ras_empty,
  output logic             o_ras_overflow
);

  localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StRedir
  } state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_pc, w_pc_d;
  logic [WIDTH-1:0] w_pc_plus_inc;
  logic [WIDTH-1:0] w_region_target;
  logic [WIDTH-1:0] w_branch_target;

  logic [WIDTH-1:0] r_ras_mem [RAS_DEPTH];
  logic [PtrW-1:0]  r_ras_wr;
  logic [CntW-1:0]  r_ras_cnt;
  logic             r_ras_ovf;
  logic [PtrW-1:0]  w_ras_top_idx;
  logic [WIDTH-1:0] w_ras_top;
  logic             w_ras_empty;
  logic             w_ras_full;
  logic             w_push;
  logic             w_pop;
  logic             w_unused_jt;

  assign w_pc_plus_inc   = r_pc + WIDTH'(INC);
  assign w_branch_target = w_pc_plus_inc + (i_branch_offset << 2);
  // Region jump: top 4 bits from pc+INC, the rest from the word index; the index bits
  // that would land in the region field are dropped.
  assign w_region_target = {w_pc_plus_inc[WIDTH-1:WIDTH-4], i_jump_target[WIDTH-7:0], 2'b00};
  assign w_unused_jt     = ^i_jump_target[WIDTH-3:WIDTH-6];

  assign w_ras_empty   = (r_ras_cnt == '0);
  assign w_ras_full    = (r_ras_cnt == CntW'(RAS_DEPTH));
  assign w_ras_top_idx = r_ras_wr - PtrW'(1);
  assign w_ras_top     = r_ras_mem[w_ras_top_idx];

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    if (i_exception) begin
      w_pc_d    = EXC_VECTOR;
      w_state_d = StRedir;
    end else begin
      unique case (r_state)
        StBoot:  w_state_d = StRun;
        StRedir: w_state_d = StRun;
        StRun: begin
          if (!i_stall) begin
            if (i_ret) begin
              w_pc_d    = w_ras_empty ? i_jr_target : w_ras_top;
              w_pop     = !w_ras_empty;
              w_state_d = StRedir;
            end else if (i_jr) begin
              w_pc_d    = i_jr_target;
              w_state_d = StRedir;
            end else if (i_call) begin
              w_pc_d    = w_region_target;
              w_push    = 1'b1;
              w_state_d = StRedir;
            end else if (i_jump) begin
              w_pc_d    = w_region_target;
              w_state_d = StRedir;
            end else if (i_branch_taken) begin
              w_pc_d    = w_branch_target;
              w_state_d = StRedir;
            end else if (i_fetch_ready) begin
              w_pc_d = w_pc_plus_inc;
            end
          end
        end
        default: w_state_d = StBoot;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StBoot;
      r_pc    <= RESET_VECTOR;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
    end
  end

  // A push when full advances the write pointer over the oldest entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ras_wr  <= '0;
      r_ras_cnt <= '0;
      r_ras_ovf <= 1'b0;
    end else if (w_push) begin
      r_ras_wr <= r_ras_wr + PtrW'(1);
      if (w_ras_full) begin
        r_ras_ovf <= 1'b1;
      end else begin
        r_ras_cnt <= r_ras_cnt + CntW'(1);
      end
    end else if (w_pop) begin
      r_ras_wr  <= w_ras_top_idx;
      r_ras_cnt <= r_ras_cnt - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ras_mem[r_ras_wr] <= w_pc_plus_inc;
    end
  end

  assign o_pc_out       = r_pc;
  assign o_pc_valid     = (r_state == StRun);
  assign o_pc_plus_inc  = w_pc_plus_inc;
  assign o_ras_empty    = w_ras_empty;
  assign o_ras_overflow = r_ras_ovf;

endmodule

// File: tb/tb_pc_unit.sv
// Directed table-driven bench for pc_unit: each row drives one cycle of inputs and
// states the outputs expected just after that clock edge.
module tb_pc_unit;

  typedef enum logic [3:0] {
    OpIdle, OpNoRdy, OpStall, OpBr, OpJmp, OpJr, OpCall, OpRet, OpExc, OpExcStallCall, OpCallRet
  } op_e;

  typedef struct packed {
    op_e         op;
    logic [31:0] arg;
    logic [31:0] pc;
    logic        vld;
    logic        emp;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall, fetch_ready, branch_taken, jump, jr, call, ret, exception;
  logic [31:0] branch_offset, jr_target;
  logic [29:0] jump_target;
  logic [31:0] pc_out, pc_plus_inc;
  logic        pc_valid, ras_empty, ras_overflow;

  vec_t tbl[$];
  int   n_total = 0;
  int   n_bad   = 0;

  pc_unit #(
    .WIDTH       (32),
    .RESET_VECTOR(32'h0),
    .EXC_VECTOR  (32'h80),
    .INC         (4),
    .RAS_DEPTH   (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_stall        (stall),
    .i_fetch_ready  (fetch_ready),
    .i_branch_taken (branch_taken),
    .i_branch_offset(branch_offset),
    .i_jump         (jump),
    .i_jump_target  (jump_target),
    .i_jr           (jr),
    .i_jr_target    (jr_target),
    .i_call         (call),
    .i_ret          (ret),
    .i_exception    (exception),
    .o_pc_out       (pc_out),
    .o_pc_valid     (pc_valid),
    .o_pc_plus_inc  (pc_plus_inc),
    .o_ras_empty    (ras_empty),
    .o_ras_overflow (ras_overflow)
  );

  always #5 clk = ~clk;

  task automatic add(input op_e op, input logic [31:0] arg, input logic [31:0] pc,
                     input logic vld, input logic emp, input logic ovf);
    tbl.push_back({op, arg, pc, vld, emp, ovf});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [31:0] pc, input logic vld,
                          input logic emp, input logic ovf);
    chk({tag, " pc"}, pc_out, pc);
    chk({tag, " pc_plus_inc"}, pc_plus_inc, pc + 32'd4);
    chk({tag, " valid"}, 32'(pc_valid), 32'(vld));
    chk({tag, " empty"}, 32'(ras_empty), 32'(emp));
    chk({tag, " ovf"}, 32'(ras_overflow), 32'(ovf));
  endtask

  task automatic drive(input op_e op, input logic [31:0] arg);
    stall = 1'b0; fetch_ready = 1'b1; branch_taken = 1'b0; jump = 1'b0; jr = 1'b0;
    call = 1'b0; ret = 1'b0; exception = 1'b0;
    branch_offset = '0; jump_target = '0; jr_target = '0;
    case (op)
      OpNoRdy: fetch_ready = 1'b0;
      OpStall: begin stall = 1'b1; branch_taken = 1'b1; branch_offset = arg;
                     ret = 1'b1; jr_target = arg; end
      OpBr:    begin branch_taken = 1'b1; branch_offset = arg; end
      OpJmp:   begin jump = 1'b1; jump_target = arg[29:0]; end
      OpJr:    begin jr = 1'b1; jr_target = arg; end
      OpCall:  begin call = 1'b1; jump_target = arg[29:0]; end
      OpRet:   begin ret = 1'b1; jr_target = arg; end
      OpExc:   begin exception = 1'b1; fetch_ready = 1'b0; end
      OpExcStallCall: begin exception = 1'b1; stall = 1'b1; call = 1'b1;
                            jump_target = arg[29:0]; end
      OpCallRet: begin call = 1'b1; ret = 1'b1; jr_target = arg; jump_target = 30'h1C0; end
      default: ;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // op, arg, expected pc, valid, ras_empty, ras_overflow (after the edge)
    add(OpIdle, 32'h0, 32'h0, 1, 1, 0);
    add(OpIdle, 32'h0, 32'h4, 1, 1, 0);
    add(OpIdle, 32'h0, 32'h8, 1, 1, 0);
    add(OpNoRdy, 32'h0, 32'h8, 1, 1, 0);
    add(OpNoRdy, 32'h0, 32'h8, 1, 1, 0);
    add(OpNoRdy, 32'h0, 32'h8, 1, 1, 0);
    add(OpIdle, 32'h0, 32'hC, 1, 1, 0);
    add(OpIdle, 32'h0, 32'h10, 1, 1, 0);
    add(OpBr, 32'hFFFF_FFFE, 32'hC, 0, 1, 0);
    add(OpIdle, 32'h0, 32'hC, 1, 1, 0);
    add(OpIdle, 32'h0, 32'h10, 1, 1, 0);
    add(OpStall, 32'hFFFF_FFFE, 32'h10, 1, 1, 0);
    add(OpIdle, 32'h0, 32'h14, 1, 1, 0);
    add(OpIdle, 32'h0, 32'h18, 1, 1, 0);
    add(OpIdle, 32'h0, 32'h1C, 1, 1, 0);
    add(OpIdle, 32'h0, 32'h20, 1, 1, 0);
    add(OpCall, 32'h40, 32'h100, 0, 0, 0);
    add(OpIdle, 32'h0, 32'h100, 1, 0, 0);
    add(OpRet, 32'hDEAD_0000, 32'h24, 0, 1, 0);
    add(OpIdle, 32'h0, 32'h24, 1, 1, 0);
    add(OpCall, 32'h100, 32'h400, 0, 0, 0);
    add(OpIdle, 32'h0, 32'h400, 1, 0, 0);
    add(OpCall, 32'h200, 32'h800, 0, 0, 0);
    add(OpIdle, 32'h0, 32'h800, 1, 0, 0);
    add(OpCall, 32'h300, 32'hC00, 0, 0, 0);
    add(OpIdle, 32'h0, 32'hC00, 1, 0, 0);
    add(OpCall, 32'h400, 32'h1000, 0, 0, 0);
    add(OpIdle, 32'h0, 32'h1000, 1, 0, 0);
    add(OpCall, 32'h500, 32'h1400, 0, 0, 1);
    add(OpIdle, 32'h0, 32'h1400, 1, 0, 1);
    add(OpRet, 32'h0, 32'h1004, 0, 0, 1);
    add(OpIdle, 32'h0, 32'h1004, 1, 0, 1);
    add(OpRet, 32'h0, 32'hC04, 0, 0, 1);
    add(OpIdle, 32'h0, 32'hC04, 1, 0, 1);
    add(OpRet, 32'h0, 32'h804, 0, 0, 1);
    add(OpIdle, 32'h0, 32'h804, 1, 0, 1);
    add(OpRet, 32'h0, 32'h404, 0, 1, 1);
    add(OpIdle, 32'h0, 32'h404, 1, 1, 1);
    add(OpRet, 32'h5550, 32'h5550, 0, 1, 1);
    add(OpIdle, 32'h0, 32'h5550, 1, 1, 1);
    add(OpCallRet, 32'h600, 32'h600, 0, 1, 1);
    add(OpIdle, 32'h0, 32'h600, 1, 1, 1);
    add(OpJmp, 32'h30, 32'hC0, 0, 1, 1);
    add(OpIdle, 32'h0, 32'hC0, 1, 1, 1);
    add(OpJr, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 1, 1);
    add(OpIdle, 32'h0, 32'hFFFF_FFFC, 1, 1, 1);
    add(OpIdle, 32'h0, 32'h0, 1, 1, 1);
    add(OpJr, 32'hF000_0000, 32'hF000_0000, 0, 1, 1);
    add(OpIdle, 32'h0, 32'hF000_0000, 1, 1, 1);
    add(OpCall, 32'h10, 32'hF000_0040, 0, 0, 1);
    add(OpIdle, 32'h0, 32'hF000_0040, 1, 0, 1);
    add(OpRet, 32'h0, 32'hF000_0004, 0, 1, 1);
    add(OpIdle, 32'h0, 32'hF000_0004, 1, 1, 1);
    add(OpJr, 32'h28, 32'h28, 0, 1, 1);
    add(OpIdle, 32'h0, 32'h28, 1, 1, 1);
    add(OpCall, 32'h8, 32'h20, 0, 0, 1);
    add(OpIdle, 32'h0, 32'h20, 1, 0, 1);
    add(OpIdle, 32'h0, 32'h24, 1, 0, 1);
    add(OpIdle, 32'h0, 32'h28, 1, 0, 1);
    add(OpIdle, 32'h0, 32'h2C, 1, 0, 1);
    add(OpIdle, 32'h0, 32'h30, 1, 0, 1);
    add(OpExcStallCall, 32'h99, 32'h80, 0, 0, 1);
    add(OpIdle, 32'h0, 32'h80, 1, 0, 1);
    add(OpRet, 32'h0, 32'h2C, 0, 1, 1);
    add(OpIdle, 32'h0, 32'h2C, 1, 1, 1);
    add(OpExc, 32'h0, 32'h80, 0, 1, 1);
    add(OpExc, 32'h0, 32'h80, 0, 1, 1);
    add(OpIdle, 32'h0, 32'h80, 1, 1, 1);
    add(OpIdle, 32'h0, 32'h84, 1, 1, 1);

    drive(OpIdle, 32'h0);
    rst = 1'b0;
    #12;
    chk_outs("reset", 32'h0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk_outs("boot", 32'h0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].op, tbl[i].arg);
      step();
      chk_outs($sformatf("row%0d", i), tbl[i].pc, tbl[i].vld, tbl[i].emp, tbl[i].ovf);
    end

    // Asynchronous reset while in the redirect bubble with a live RAS entry.
    drive(OpCall, 32'h40);
    step();
    chk_outs("pre_rst_call", 32'h100, 1'b0, 1'b0, 1'b1);
    drive(OpIdle, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    chk_outs("async_rst", 32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_outs("boot2", 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    chk_outs("run2", 32'h0, 1'b1, 1'b1, 1'b0);
    drive(OpRet, 32'h44);
    step();
    chk_outs("ret_after_rst", 32'h44, 1'b0, 1'b1, 1'b0);
    drive(OpIdle, 32'h0);
    step();
    chk_outs("run3", 32'h44, 1'b1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
